// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: holds the $FF46 register, runs the start-up delay and walks
// the source page into OAM, producing the bus/interrupt qualifiers for the mux.
module oam_dma_ctrl #(
    parameter int SETUP_CYCLES = 4,
    parameter int CYC_PER_BYTE = 4,
    parameter int XFER_LEN     = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic        reg_hit,
    output logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        intq_mask,
    output logic [15:0] src_addr,
    output logic        src_rd,
    output logic        src_vram,
    input  logic [7:0]  src_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        cpu_ext_ok,
    output logic        cpu_hram_ok
);

    localparam int XFER_CYCLES = XFER_LEN * CYC_PER_BYTE;
    localparam int CYC_W       = $clog2(XFER_CYCLES);
    localparam int SET_W       = $clog2(SETUP_CYCLES + 1);
    localparam int BYTE_SH     = $clog2(CYC_PER_BYTE);

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(XFER_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETUP_CYCLES);
    localparam logic [15:0]      DMA_REG   = 16'hFF46;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t           state_r;
    logic [CYC_W-1:0] cyc_cnt_r;
    logic [SET_W-1:0] setup_cnt_r;
    logic             setup_pending_r;
    logic [7:0]       pend_base_r;
    logic [7:0]       active_base_r;
    logic [7:0]       reg_rdata_r;

    logic             trigger_s;
    logic             setup_done_s;
    logic             busy_s;
    logic [7:0]       idx_s;
    logic [7:0]       src_hi_s;
    logic [15:0]      src_addr_s;
    logic             src_vram_s;

    assign trigger_s    = cpu_wr && (cpu_addr == DMA_REG);
    assign setup_done_s = setup_pending_r && (setup_cnt_r == SET_LAST);
    assign busy_s       = (state_r == ST_XFER);
    assign idx_s        = 8'(cyc_cnt_r >> BYTE_SH);

    // Register, setup delay and transfer sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            cyc_cnt_r       <= '0;
            setup_cnt_r     <= '0;
            setup_pending_r <= 1'b0;
            pend_base_r     <= 8'h00;
            active_base_r   <= 8'h00;
            reg_rdata_r     <= 8'h00;
        end else begin
            if (trigger_s) begin
                reg_rdata_r     <= cpu_wdata;
                pend_base_r     <= cpu_wdata;
                setup_pending_r <= 1'b1;
                setup_cnt_r     <= SET_W'(1);
            end else if (setup_done_s) begin
                setup_pending_r <= 1'b0;
                setup_cnt_r     <= '0;
            end else if (setup_pending_r) begin
                setup_cnt_r     <= setup_cnt_r + SET_W'(1);
            end else begin
                setup_cnt_r     <= setup_cnt_r;
            end

            // A finishing setup restarts the walk, even mid-byte or on the final cycle.
            if (setup_done_s) begin
                state_r       <= ST_XFER;
                cyc_cnt_r     <= '0;
                active_base_r <= pend_base_r;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cyc_cnt_r <= '0;
                    end
                    ST_XFER: begin
                        if (cyc_cnt_r == CYC_LAST) begin
                            state_r   <= ST_IDLE;
                            cyc_cnt_r <= '0;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                        end
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        cyc_cnt_r <= '0;
                    end
                endcase
            end
        end
    end

    // Echo RAM pages $E0-$FF read through to $C0-$DF.
    always_comb begin
        src_hi_s = active_base_r;
        if (active_base_r >= 8'hE0) begin
            src_hi_s = active_base_r - 8'h20;
        end else begin
            src_hi_s = active_base_r;
        end
    end

    // Source and OAM side of the transfer; all quiet outside XFER.
    always_comb begin
        src_addr_s = 16'h0000;
        src_rd     = 1'b0;
        oam_we     = 1'b0;
        oam_addr   = 8'h00;
        oam_wdata  = 8'h00;
        if (busy_s) begin
            src_addr_s = {src_hi_s, 8'h00} + {8'h00, idx_s};
            src_rd     = 1'b1;
            oam_we     = 1'b1;
            oam_addr   = idx_s;
            oam_wdata  = src_data;
        end else begin
            src_addr_s = 16'h0000;
        end
    end

    assign src_vram_s = (src_addr_s >= 16'h8000) && (src_addr_s <= 16'h9FFF);

    assign src_addr    = src_addr_s;
    assign src_vram    = src_vram_s;
    assign busy        = busy_s;
    assign intq_mask   = busy_s;
    assign reg_rdata   = reg_rdata_r;
    assign reg_hit     = cpu_rd && (cpu_addr == DMA_REG);
    assign cpu_hram_ok = busy_s && (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    // The CPU keeps the external bus only while DMA is reading from VRAM.
    assign cpu_ext_ok  = busy_s && src_vram_s &&
                         ((cpu_addr <= 16'h7FFF) ||
                          ((cpu_addr >= 16'hA000) && (cpu_addr <= 16'hFDFF)));

endmodule
